// File: rtl/poisson_pkg.sv
// rtl/poisson_pkg.sv - shared types, constants and PRNG helpers for the Poisson rate encoder
package poisson_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PRNG_WIDTH = 16;
    localparam int XS_A = 7;
    localparam int XS_B = 9;
    localparam int XS_C = 8;

    // Channels are decorrelated by a golden-ratio multiple; xorshift cannot leave zero.
    function automatic logic [PRNG_WIDTH-1:0] seed_for_ch(input logic [PRNG_WIDTH-1:0] base,
                                                          input int c);
        logic [PRNG_WIDTH-1:0] s;
        s = base ^ PRNG_WIDTH'(c * 32'h0000_9E37);
        if (s == '0) begin
            s = PRNG_WIDTH'(1);
        end
        return s;
    endfunction

    function automatic logic [PRNG_WIDTH-1:0] xorshift_step(input logic [PRNG_WIDTH-1:0] x);
        logic [PRNG_WIDTH-1:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

endpackage

// File: rtl/poisson_lfsr_channel.sv
// rtl/poisson_lfsr_channel.sv - one 16-bit xorshift generator, stepped only on request
module poisson_lfsr_channel
    import poisson_pkg::*;
#(
    parameter logic [PRNG_WIDTH-1:0] SEED = 16'h0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [PRNG_WIDTH-1:0] state
);

    logic [PRNG_WIDTH-1:0] state_q;
    logic [PRNG_WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = xorshift_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/multichannel_poisson_encoder.sv
// rtl/multichannel_poisson_encoder.sv - NUM_CH-channel Poisson spike encoder with windowed output
// Optional per-channel spike statistics are built when POISSON_STATS_EN is defined.
module multichannel_poisson_encoder
    import poisson_pkg::*;
#(
    parameter int              NUM_CH     = 4,
    parameter int              DATA_WIDTH = 8,
    parameter int              WINDOW_LEN = 64,
    parameter int              CNT_WIDTH  = 8,
    parameter logic [15:0]     SEED_BASE  = 16'hACE1,
    localparam int             STEP_W     = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rate_valid,
    output logic                           rate_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   rate_data,
    input  logic                           abort,
    output logic                           spike_valid,
    input  logic                           spike_ready,
    output logic [NUM_CH-1:0]              spike_out,
    output logic [STEP_W-1:0]              step_idx,
    output logic                           window_done,
    output logic                           busy,
    output logic [NUM_CH*CNT_WIDTH-1:0]    spike_count,
    output logic [NUM_CH-1:0]              stats_sat
);

    state_t                         state_q, state_d;
    logic [NUM_CH*DATA_WIDTH-1:0]   rate_q, rate_d;
    logic                           ready_q, ready_d;
    logic                           valid_q, valid_d;
    logic [NUM_CH-1:0]              spike_q, spike_d;
    logic [STEP_W-1:0]              step_q, step_d;

    logic [NUM_CH-1:0]              spike_cur;
    logic [NUM_CH-1:0]              spike_nxt;
    logic                           accept;
    logic                           capture;
    logic                           last_step;

    assign accept    = valid_q && spike_ready;
    assign capture   = (state_q == IDLE) && rate_valid && ready_q;
    assign last_step = (step_q == STEP_W'(WINDOW_LEN - 1));

    // spike_nxt looks one PRNG step ahead so the beat after an acceptance is ready at once.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PRNG_WIDTH-1:0] prng_st;
        logic [PRNG_WIDTH-1:0] hi_cur;
        logic [PRNG_WIDTH-1:0] hi_nxt;
        logic [PRNG_WIDTH-1:0] rate_ext;

        poisson_lfsr_channel #(
            .SEED (seed_for_ch(SEED_BASE, c))
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .advance (accept),
            .state   (prng_st)
        );

        assign hi_cur       = prng_st >> (PRNG_WIDTH - DATA_WIDTH);
        assign hi_nxt       = xorshift_step(prng_st) >> (PRNG_WIDTH - DATA_WIDTH);
        assign rate_ext     = PRNG_WIDTH'(rate_q[c*DATA_WIDTH +: DATA_WIDTH]);
        assign spike_cur[c] = hi_cur < rate_ext;
        assign spike_nxt[c] = hi_nxt < rate_ext;
    end

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        valid_d = valid_q;
        spike_d = spike_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    rate_d  = rate_data;
                    step_d  = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    spike_d = '0;
                end else if (!valid_q) begin
                    valid_d = 1'b1;
                    spike_d = spike_cur;
                end else if (accept) begin
                    if (last_step) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        spike_d = '0;
                        step_d  = '0;
                    end else begin
                        step_d  = step_q + 1'b1;
                        spike_d = spike_nxt;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                spike_d = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rate_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            spike_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            spike_q <= spike_d;
            step_q  <= step_d;
        end
    end

    assign rate_ready  = ready_q;
    assign spike_valid = valid_q;
    assign spike_out   = spike_q;
    assign step_idx    = step_q;
    assign window_done = (state_q == DONE);
    assign busy        = (state_q != IDLE);

`ifdef POISSON_STATS_EN
    logic [NUM_CH*CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]           sat_q, sat_d;

    // A spike arriving at an all-ones counter is the overflow that sets the sticky flag.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (capture) begin
            cnt_d = '0;
            sat_d = '0;
        end else if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (spike_q[c]) begin
                    if (&cnt_q[c*CNT_WIDTH +: CNT_WIDTH]) begin
                        sat_d[c] = 1'b1;
                    end else begin
                        cnt_d[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign spike_count = cnt_q;
    assign stats_sat   = sat_q;
`else
    assign spike_count = '0;
    assign stats_sat   = '0;
`endif

endmodule

// File: doc/multichannel_poisson_encoder.md
# multichannel_poisson_encoder

Parametrised, multi-channel successor to the single-channel Poisson rate encoder. Accepts a vector of NUM_CH rate values through a valid/ready handshake and emits a fixed-length window of WINDOW_LEN spike vectors, each channel driven by its own 16-bit xorshift generator. The output has valid/ready backpressure, so the block feeds the LIF neuron array or a spike FIFO directly.

## Interface
- NUM_CH, 4, number of encoder channels (1..64)
- DATA_WIDTH, 8, rate width per channel (1..16)
- WINDOW_LEN, 64, spike vectors emitted per accepted rate vector (≥2)
- CNT_WIDTH, 8, per-channel spike counter width (≥1)
- SEED_BASE, 16'hACE1, base seed for channel PRNGs
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rate_valid  in  1  rate vector present
- rate_ready  out  1  block can accept a rate vector
- rate_data  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- abort  in  1  terminate the current window
- spike_valid  out  1  spike_out holds a valid beat
- spike_ready  in  1  downstream accepts the beat
- spike_out  out  NUM_CH  one spike bit per channel
- step_idx  out  $clog2(WINDOW_LEN)  time step of the current beat
- window_done  out  1  one-cycle pulse after the last beat is accepted
- busy  out  1  window in progress
- spike_count  out  NUM_CH*CNT_WIDTH  per-channel spike totals for the current window
- stats_sat  out  NUM_CH  sticky per-channel counter saturation flag

## Operation
- FSM states: IDLE, GEN, DONE. Reset state: IDLE.
- IDLE: rate_ready=1. When rate_valid&&rate_ready:
  - capture rate_data into the rate register;
  - clear step_idx, spike_count and stats_sat;
  - go to GEN.
- GEN: spike register = {prng_hi[c] < rate[c]}, where prng_hi is the upper DATA_WIDTH bits of channel c's PRNG state. spike_valid=1.
- Beat acceptance = spike_valid&&spike_ready. On acceptance:
  - all PRNGs advance one step;
  - step_idx increments;
  - the next beat is registered.
- PRNGs advance only on accepted beats. The spike sequence is therefore independent of backpressure.
- While spike_valid&&!spike_ready, spike_out and step_idx hold stable.
- Acceptance with step_idx==WINDOW_LEN-1 → DONE. DONE lasts one cycle with window_done=1, then IDLE.
- abort in GEN → IDLE next cycle. spike_valid drops, no window_done, counters keep their values. abort is ignored in IDLE and DONE.
- PRNG state is not reset between windows; it continues across windows.
- Rate boundaries: rate 0 never spikes. Rate 2^DATA_WIDTH-1 spikes except when prng_hi is all-ones.
- PRNG: 16-bit xorshift, x^=x<<7; x^=x>>9; x^=x<<8. Seed(c) = SEED_BASE ^ (c*16'h9E37); a zero seed is forced to 16'h0001.
- busy = (state != IDLE).

## Timing
- Reset values:
  - rate_ready=0 while rst is high, 1 on the first edge after deassertion;
  - spike_valid, spike_out, step_idx, window_done, busy, spike_count, stats_sat = 0;
  - PRNGs = seeds.
- Latency: rate handshake at edge k → spike_valid=1 after edge k+1.
- Throughput: one beat per cycle with spike_ready held high. A full window spans WINDOW_LEN cycles + 1 DONE cycle + 1 IDLE cycle before the next rate is accepted.
- rate_ready is 0 throughout GEN and DONE; rate_data is not sampled there.
- Reset mid-window returns all state to reset values immediately (asynchronous).

## Configuration
- POISSON_STATS_EN defined:
  - each accepted beat with spike_out[c]=1 increments spike_count[c];
  - at all-ones the counter holds and stats_sat[c] sets sticky until the next rate capture.
- POISSON_STATS_EN undefined: the counter logic is removed, and spike_count and stats_sat are tied to 0.

## Structure
- Package poisson_pkg holds:
  - state enum (IDLE/GEN/DONE);
  - PRNG_WIDTH=16;
  - xorshift shift constants 7/9/8;
  - function seed_for_ch(base, c).
- Sub-module poisson_lfsr_channel: one PRNG, ports clk, rst, advance, seed (parameter), state out. It is instantiated NUM_CH times in a generate loop.

## Test plan
- Rates all 0, spike_ready=1 → 64 beats, spike_out=0 every beat, window_done pulses at the cycle after beat 63, spike_count all 0.
- Rates {255,128,64,0}, WINDOW_LEN=64, no backpressure → spike_out bit-exact vs reference model; spike_count[1] within 20..44, spike_count[3]=0.
- Same stimulus with spike_ready randomly toggled ~50% → identical beat sequence and counts to the no-backpressure run; spike_out and step_idx stable while stalled.
- abort asserted at step 10 → spike_valid=0 next cycle, no window_done, rate_ready=1 one cycle later; the next window continues the PRNG sequence.
- CNT_WIDTH=4, rate 255 (with POISSON_STATS_EN) → spike_count saturates at 15, stats_sat=1; cleared on the next rate capture.
- rst pulse mid-GEN → all outputs 0 immediately; after release rate_ready=1 and the first beat equals the post-reset seed value.
